// File: rtl/mem_c_unskew_if.sv
// Bundle of the enable, skewed result lanes and aligned row outputs around mem_c_unskew.
// The master drives the skewed lanes; the slave (the unskew block) returns aligned rows.
interface mem_c_unskew_if #(
  parameter int BITS_C = 24,
  parameter int DIM    = 8
);
  localparam int RIDX_W = (DIM > 1) ? $clog2(DIM) : 1;

  logic                         en;
  logic                         valid_in;
  logic [DIM-1:0][BITS_C-1:0]   Cin;
  logic [DIM-1:0][BITS_C-1:0]   Cout;
  logic                         out_valid;
  logic [RIDX_W-1:0]            row_idx;
  logic                         done;

  modport master (
    output en, valid_in, Cin,
    input  Cout, out_valid, row_idx, done
  );

  modport slave (
    input  en, valid_in, Cin,
    output Cout, out_valid, row_idx, done
  );
endinterface

// File: rtl/mem_c_unskew.sv
// Realigns the diagonally skewed result lanes of the systolic array into whole rows of C,
// tagging each row with its index and pulsing done on the last row of a matrix.
module mem_c_unskew #(
  parameter int BITS_C = 24,
  parameter int DIM    = 8
) (
  input logic            clk,
  input logic            rst,
  mem_c_unskew_if.slave  bus
);
  localparam int RIDX_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(DIM - 1);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_e;

  logic [DIM-1:0][BITS_C-1:0] lane_out;
  logic                       tag_last;

  // Lane j lags lane 0 by j cycles, so it needs DIM-1-j stages to line up.
  for (genvar j = 0; j < DIM; j++) begin : g_lane
    localparam int NS = DIM - 1 - j;
    if (NS == 0) begin : g_direct
      assign lane_out[j] = bus.Cin[j];
    end else begin : g_delay
      logic [BITS_C-1:0] stage_q [NS];

      // NOTE: these stages are individual flops, so they are cleared on reset to drop in-flight rows.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < NS; i++) stage_q[i] <= '0;
        end else if (bus.en) begin
          stage_q[0] <= bus.Cin[j];
          for (int i = 1; i < NS; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign lane_out[j] = stage_q[NS-1];
    end
  end

  if (DIM > 1) begin : g_tag
    logic [DIM-2:0] tag_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        tag_q <= '0;
      end else if (bus.en) begin
        tag_q[0] <= bus.valid_in;
        for (int i = 1; i < DIM - 1; i++) tag_q[i] <= tag_q[i-1];
      end
    end

    assign tag_last = tag_q[DIM-2];
  end else begin : g_no_tag
    assign tag_last = bus.valid_in;
  end

  state_e                     state_q;
  logic [RIDX_W-1:0]          cnt_q;
  logic [DIM-1:0][BITS_C-1:0] cout_q;
  logic                       out_valid_q;
  logic                       done_q;
  logic [RIDX_W-1:0]          row_idx_q;

  // Row counter FSM with registered outputs; a disabled edge only squashes the strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cout_q      <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      row_idx_q   <= '0;
    end else if (!bus.en) begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cout_q      <= lane_out;
      out_valid_q <= tag_last;
      done_q      <= 1'b0;
      if (tag_last) begin
        unique case (state_q)
          IDLE: begin
            row_idx_q <= '0;
            if (DIM == 1) begin
              done_q <= 1'b1;
            end else begin
              cnt_q   <= RIDX_W'(1);
              state_q <= COLLECT;
            end
          end
          COLLECT: begin
            row_idx_q <= cnt_q;
            if (cnt_q == LAST_ROW) begin
              done_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + RIDX_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.Cout      = cout_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;
  assign bus.row_idx   = row_idx_q;
endmodule

// File: tb/tb_mem_c_unskew.sv
// Directed and random stimulus for mem_c_unskew, checked against a row-level model that
// remembers every row offered on an enabled edge and counts valid rows per matrix.
module tb_mem_c_unskew;
  localparam int DIM    = 4;
  localparam int BITS_C = 16;
  localparam int RW     = $clog2(DIM);

  typedef logic [DIM-1:0][BITS_C-1:0] row_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_c_unskew_if #(.BITS_C(BITS_C), .DIM(DIM)) bus ();

  mem_c_unskew #(.BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model state: rows offered on enabled edges since the last reset.
  row_t          hist[$];
  bit            vhist[$];
  int            vcount;
  logic [RW-1:0] exp_ridx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic row_t rand_row();
    row_t r;
    for (int c = 0; c < DIM; c++) r[c] = BITS_C'($urandom);
    return r;
  endfunction

  function automatic row_t seq_row(input int base);
    row_t r;
    for (int c = 0; c < DIM; c++) r[c] = BITS_C'(base + c);
    return r;
  endfunction

  // One clock: present row r as the lane-0 start of a new row (lane j carries the row
  // offered j enabled edges earlier), then compare against the model #1 after the edge.
  task automatic step(input bit r_rst, input bit e, input bit v, input row_t r, input string tag);
    int   n;
    int   idx;
    bit   exp_valid;
    bit   exp_done;
    row_t exp_row;
    n = hist.size();
    rst          = r_rst;
    bus.en       = e;
    bus.valid_in = v;
    for (int j = 0; j < DIM; j++) begin
      if (j == 0)      bus.Cin[j] = r[0];
      else if (n >= j) bus.Cin[j] = hist[n-j][j];
      else             bus.Cin[j] = BITS_C'($urandom);
    end
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    exp_row   = '0;
    if (r_rst) begin
      hist.delete();
      vhist.delete();
      vcount   = 0;
      exp_ridx = '0;
    end else if (e) begin
      hist.push_back(r);
      vhist.push_back(v);
      idx = hist.size() - DIM;
      if (idx >= 0 && vhist[idx]) begin
        exp_valid = 1'b1;
        exp_row   = hist[idx];
        exp_ridx  = RW'(vcount % DIM);
        exp_done  = (vcount % DIM) == DIM - 1;
        vcount++;
      end
    end
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(exp_valid));
    chk({tag, ".done"},      64'(bus.done),      64'(exp_done));
    chk({tag, ".row_idx"},   64'(bus.row_idx),   64'(exp_ridx));
    if (exp_valid || r_rst) chk({tag, ".Cout"}, 64'(bus.Cout), 64'(exp_row));
  endtask

  task automatic flush(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, rand_row(), tag);
  endtask

  initial begin
    row_t r;
    int   rr;
    int   budget;
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.valid_in = 1'b0;
    bus.Cin      = '0;
    vcount       = 0;
    exp_ridx     = '0;

    // 1: reset held with random inputs, then one frozen cycle after release
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'($urandom), rand_row(), "t1_rst");
    step(1'b0, 1'b0, 1'b0, rand_row(), "t1_post");
    chk("t1_post.Cout", 64'(bus.Cout), 64'(0));

    // 2: single matrix with en held high
    for (int i = 0; i < DIM; i++) step(1'b0, 1'b1, 1'b1, seq_row(16 * i), "t2");
    flush(DIM, "t2_flush");

    // 3: same matrix with stalls on cycles 2 and 5
    rr = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc == 2 || cyc == 5)  step(1'b0, 1'b0, 1'($urandom), rand_row(), "t3_stall");
      else if (rr < DIM) begin
        step(1'b0, 1'b1, 1'b1, seq_row(16 * rr), "t3");
        rr++;
      end else                   step(1'b0, 1'b1, 1'b0, rand_row(), "t3_tail");
    end

    // 4: extreme signed values rotated across lanes
    for (int i = 0; i < DIM; i++) begin
      for (int c = 0; c < DIM; c++) begin
        case ((c + i) % 4)
          0:       r[c] = 16'h8000;
          1:       r[c] = 16'h7fff;
          2:       r[c] = 16'hffff;
          default: r[c] = 16'h0000;
        endcase
      end
      step(1'b0, 1'b1, 1'b1, r, "t4");
    end
    flush(DIM, "t4_flush");

    // 5: two matrices back to back with a bubble after row 1 of the second
    for (int i = 0; i < 2 * DIM; i++) begin
      step(1'b0, 1'b1, 1'b1, rand_row(), "t5");
      if (i == DIM + 1) step(1'b0, 1'b1, 1'b0, rand_row(), "t5_bubble");
    end
    flush(DIM, "t5_flush");

    // 6: reset once two rows have come out, then a fresh full matrix
    vcount = 0;
    budget = 0;
    rr     = 0;
    while (vcount < 2 && budget < 20) begin
      step(1'b0, 1'b1, rr < DIM, rand_row(), "t6_pre");
      rr++;
      budget++;
    end
    chk("t6_rows_before_reset", 64'(vcount), 64'(2));
    step(1'b1, 1'b1, 1'b1, rand_row(), "t6_rst");
    for (int i = 0; i < DIM; i++) step(1'b0, 1'b1, 1'b1, rand_row(), "t6");
    flush(DIM, "t6_flush");

    // random traffic with stalls, bubbles and occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(3) != 0), ($urandom_range(2) != 0),
           rand_row(), "rnd");
    end
    flush(DIM, "rnd_flush");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
